sm_encoder_stream: RTL and testbench

- Streaming encoder that converts two's-complement samples to sign-magnitude words. It is the inverse of the signed comparator front end, which decodes sign-magnitude into two's complement.
- Sits between the datapath arithmetic and any sign-magnitude consumer, such as comparator operand buses or display or I/O ports.
- Valid/ready handshake on both sides, with a 2-entry skid buffer so throughput is 1 word/cycle with a registered ready.
- Tracks saturation events: the most negative two's-complement value has no sign-magnitude encoding.

---
 rtl/sm_pkg.sv | 56 +++++
 rtl/sm_skid_buf.sv | 85 ++++++++
 rtl/sm_encoder_stream.sv | 77 +++++++
 tb/tb_sm_encoder_stream.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_pkg.sv
// Shared sign-magnitude helpers and the skid-buffer state type.
package sm_pkg;

  // Helpers work on 16-bit containers, which covers every supported width.
  localparam int SM_MAX_W = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  // Most negative two's-complement value of a w-bit word: 1 followed by zeros.
  function automatic logic [SM_MAX_W-1:0] SM_MIN_TC(input int w);
    return SM_MAX_W'(1) << (w - 1);
  endfunction

  // Mask covering the w-1 magnitude bits.
  function automatic logic [SM_MAX_W-1:0] sm_mag_mask(input int w);
    return SM_MIN_TC(w) - SM_MAX_W'(1);
  endfunction

  // Saturated encoding of MIN: sign set, magnitude all ones.
  function automatic logic [SM_MAX_W-1:0] SM_SAT_VAL(input int w);
    return SM_MIN_TC(w) | sm_mag_mask(w);
  endfunction

  // Two's complement -> sign-magnitude. MIN saturates; negative zero cannot occur
  // because a negative input always has a nonzero magnitude.
  function automatic logic [SM_MAX_W-1:0] tc_to_sm(input logic [SM_MAX_W-1:0] x,
                                                   input int w);
    logic [SM_MAX_W-1:0] xm;
    logic [SM_MAX_W-1:0] mag;
    xm  = x & SM_SAT_VAL(w);
    mag = (~xm + SM_MAX_W'(1)) & sm_mag_mask(w);
    if ((xm & SM_MIN_TC(w)) == '0) begin
      return xm;
    end
    if (xm == SM_MIN_TC(w)) begin
      return SM_SAT_VAL(w);
    end
    return SM_MIN_TC(w) | mag;
  endfunction

  // Sign-magnitude -> two's complement. Negative zero decodes to zero.
  function automatic logic [SM_MAX_W-1:0] sm_to_tc(input logic [SM_MAX_W-1:0] x,
                                                   input int w);
    logic [SM_MAX_W-1:0] mag;
    mag = x & sm_mag_mask(w);
    if ((x & SM_MIN_TC(w)) == '0) begin
      return mag;
    end
    return (~mag + SM_MAX_W'(1)) & SM_SAT_VAL(w);
  endfunction

endpackage

// File: rtl/sm_skid_buf.sv
// Two-entry valid/ready skid buffer with registered in_ready, out_valid and out_data.
// The head slot drives out_data directly, so output is stable while stalled.
module sm_skid_buf
  import sm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             push;
  logic             pop;

  assign push = in_valid && in_ready_q;
  assign pop  = out_valid_q && out_ready;

  // Next-state and slot updates; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = in_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = in_data;
        end else if (push) begin
          tail_d  = in_data;
          state_d = TWO;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so only a drain can happen.
        if (pop) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != TWO);
  end

  // State register; reset empties both slots and holds in_ready low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      tail_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = head_q;

endmodule

// File: rtl/sm_encoder_stream.sv
// Streaming two's-complement to sign-magnitude encoder with saturation tracking.
// Words are encoded on the way into the skid buffer; saturation is counted at acceptance.
module sm_encoder_stream
  import sm_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             sat_flag,
  output logic [CNT_W-1:0] sat_cnt,
  input  logic             sat_clr
);

  localparam logic [WIDTH-1:0] MIN_TC  = WIDTH'(SM_MIN_TC(WIDTH));
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] enc_data;
  logic             accept;
  logic             sat_hit;
  logic             sat_flag_q, sat_flag_d;
  logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;

  assign enc_data = WIDTH'(tc_to_sm(SM_MAX_W'(in_data), WIDTH));
  assign accept   = in_valid && in_ready;
  assign sat_hit  = accept && (in_data == MIN_TC);

  sm_skid_buf #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (enc_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  // Saturation bookkeeping: a saturating accept beats a simultaneous clear.
  always_comb begin
    sat_flag_d = sat_flag_q;
    sat_cnt_d  = sat_cnt_q;
    if (sat_clr) begin
      sat_flag_d = sat_hit;
      sat_cnt_d  = sat_hit ? CNT_W'(1) : '0;
    end else if (sat_hit) begin
      sat_flag_d = 1'b1;
      if (sat_cnt_q != CNT_MAX) begin
        sat_cnt_d = sat_cnt_q + CNT_W'(1);
      end
    end
  end

  // Saturation registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_flag_q <= 1'b0;
      sat_cnt_q  <= '0;
    end else begin
      sat_flag_q <= sat_flag_d;
      sat_cnt_q  <= sat_cnt_d;
    end
  end

  assign sat_flag = sat_flag_q;
  assign sat_cnt  = sat_cnt_q;

endmodule

// File: tb/tb_sm_encoder_stream.sv
// Scoreboard bench for sm_encoder_stream: expected words queued at acceptance,
// compared when the DUT transfers them out.
module tb_sm_encoder_stream;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       sat_flag;
  logic [7:0] sat_cnt;
  logic       sat_clr;

  // Second instance with a 2-bit counter for the hold-at-max case.
  logic       in_valid2;
  logic       in_ready2;
  logic [7:0] in_data2;
  logic       out_valid2;
  logic       out_ready2;
  logic [7:0] out_data2;
  logic       sat_flag2;
  logic [1:0] sat_cnt2;
  logic       sat_clr2;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] d;
    int         c;
  } exp_t;
  exp_t sb_q[$];

  logic       chk_lat = 1'b0;
  logic       m_flag = 1'b0;
  logic [7:0] m_cnt = 8'd0;
  logic       stall_prev = 1'b0;
  logic [7:0] stall_data = 8'd0;

  sm_encoder_stream #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sat_flag(sat_flag), .sat_cnt(sat_cnt), .sat_clr(sat_clr)
  );

  sm_encoder_stream #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .sat_flag(sat_flag2), .sat_cnt(sat_cnt2), .sat_clr(sat_clr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference encoder written from the arithmetic definition.
  function automatic logic [7:0] model_enc(input logic [7:0] x);
    int v;
    v = $signed(x);
    if (v >= 0) return x;
    if (v == -128) return 8'hFF;
    return {1'b1, 7'(-v)};
  endfunction

  // Monitor on the falling edge: check state left by the last rising edge,
  // then predict what the coming rising edge will do.
  always @(negedge clk) begin
    exp_t e;
    logic hit;
    if (stall_prev) begin
      check_val("stall_valid", 32'(out_valid), 32'd1);
      check_val("stall_data", 32'(out_data), 32'(stall_data));
    end
    check_val("sat_flag_track", 32'(sat_flag), 32'(m_flag));
    check_val("sat_cnt_track", 32'(sat_cnt), 32'(m_cnt));
    if (!rst_n) begin
      sb_q.delete();
      m_flag = 1'b0;
      m_cnt = 8'd0;
      stall_prev = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        check_val("out_has_exp", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          $display("out  cyc=%0d data=%02h exp=%02h", cyc + 1, out_data, e.d);
          check_val("out_data", 32'(out_data), 32'(e.d));
          if (chk_lat) check_val("latency", 32'(cyc + 1 - e.c), 32'd1);
        end
      end
      hit = in_valid && in_ready && (in_data == 8'h80);
      if (in_valid && in_ready) begin
        e.d = model_enc(in_data);
        e.c = cyc + 1;
        sb_q.push_back(e);
        $display("in   cyc=%0d data=%02h", cyc + 1, in_data);
      end
      if (sat_clr) begin
        m_flag = hit;
        m_cnt = hit ? 8'd1 : 8'd0;
      end else if (hit) begin
        m_flag = 1'b1;
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
    end
  end

  // Present a word and hold it until accepted; optionally toggle out_ready each cycle.
  task automatic send(input logic [7:0] w, input bit tog);
    logic ok;
    int n;
    in_data = w;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (tog) out_ready = ~out_ready;
      n++;
    end while (!ok && n < 50);
    if (!ok) check_val("accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    logic [7:0] basic_in[5] = '{8'h05, 8'hFB, 8'h00, 8'h7F, 8'h81};
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; sat_clr = 1'b0;
    in_valid2 = 1'b0; in_data2 = 8'h80; out_ready2 = 1'b1; sat_clr2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_in_ready", 32'(in_ready), 32'd0);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_out_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("rel_in_ready", 32'(in_ready), 32'd1);

    // Basic encode at full rate with latency checking.
    out_ready = 1'b1;
    chk_lat = 1'b1;
    foreach (basic_in[i]) send(basic_in[i], 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk_lat = 1'b0;
    drain();
    check_val("basic_sat_cnt", 32'(sat_cnt), 32'd0);

    // Saturation and clear behaviour.
    send(8'h80, 1'b0);
    send(8'h80, 1'b0);
    send(8'h01, 1'b0);
    drain();
    check_val("sat_flag_set", 32'(sat_flag), 32'd1);
    check_val("sat_cnt_two", 32'(sat_cnt), 32'd2);
    sat_clr = 1'b1;
    @(posedge clk);
    #1;
    sat_clr = 1'b0;
    check_val("clr_flag", 32'(sat_flag), 32'd0);
    check_val("clr_cnt", 32'(sat_cnt), 32'd0);
    sat_clr = 1'b1;
    send(8'h80, 1'b0);
    sat_clr = 1'b0;
    in_valid = 1'b0;
    check_val("clr_hit_flag", 32'(sat_flag), 32'd1);
    check_val("clr_hit_cnt", 32'(sat_cnt), 32'd1);
    drain();

    // Backpressure: only two words fit while the output is stalled.
    out_ready = 1'b0;
    send(8'h10, 1'b0);
    send(8'h11, 1'b0);
    in_data = 8'h12;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("bp_in_ready", 32'(in_ready), 32'd0);
    check_val("bp_queued", 32'(sb_q.size()), 32'd2);
    check_val("bp_head", 32'(out_data), 32'h10);
    out_ready = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    send(8'h12, 1'b0);
    drain();

    // Throughput with out_ready toggling and random data.
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) send(8'($urandom_range(0, 255)), 1'b1);
    drain();

    // Reset while both slots are full.
    out_ready = 1'b0;
    send(8'h80, 1'b0);
    send(8'h22, 1'b0);
    in_valid = 1'b0;
    check_val("pre_rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_val("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check_val("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check_val("mid_rst_sat_cnt", 32'(sat_cnt), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("post_rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_val("post_rst_out_valid", 32'(out_valid), 32'd0);

    // Counter holds at all-ones with a 2-bit counter.
    in_valid2 = 1'b1;
    n = 0;
    for (int k = 0; k < 50 && n < 5; k++) begin
      @(negedge clk);
      if (in_ready2) n++;
      @(posedge clk);
      #1;
    end
    in_valid2 = 1'b0;
    check_val("wrap_accepts", 32'(n), 32'd5);
    check_val("wrap_cnt", 32'(sat_cnt2), 32'd3);
    check_val("wrap_flag", 32'(sat_flag2), 32'd1);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
